// File: rtl/radix4_booth_pkg.sv
// ---------------------------------------------------------------------------
// radix4_booth_pkg
// Shared definitions for the radix-4 Booth multiplier slice:
//   booth_state_e  - controller FSM state type (IDLE, LOAD, RUN, CAPT)
//   MIN_WIDTH      - smallest legal operand width
//   num_shifts()   - number of radix-4 iterations, ceil(width/2)
// ---------------------------------------------------------------------------
package radix4_booth_pkg;

    localparam int MIN_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_CAPT
    } booth_state_e;

    function automatic int num_shifts(input int width);
        return (width + 1) / 2;
    endfunction

endpackage

// File: rtl/radix4_booth_data_path.sv
// ---------------------------------------------------------------------------
// radix4_booth_data_path
// Iterative radix-4 Booth signed multiplier data path, one recoded digit per
// enabled cycle.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   i_start           - load operands and clear the accumulator
//   i_en              - perform one Booth iteration
//   i_rst_cntr_n      - synchronous clear of the iteration counter (active-low)
//   i_multiplier      - signed multiplier, WIDTH bits
//   i_multiplicand    - signed multiplicand, WIDTH bits
//   o_done            - high during the last iteration cycle
//   o_result          - signed product, 2*WIDTH bits
// ---------------------------------------------------------------------------
module radix4_booth_data_path
    import radix4_booth_pkg::*;
#(
    parameter int WIDTH = 8
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic                 i_en,
    input  logic                 i_rst_cntr_n,
    input  logic [WIDTH-1:0]     i_multiplier,
    input  logic [WIDTH-1:0]     i_multiplicand,
    output logic                 o_done,
    output logic [2*WIDTH-1:0]   o_result
);

    localparam int NSHIFT = num_shifts(WIDTH);
    localparam int PW     = 2 * WIDTH;
    localparam int MW     = 2 * NSHIFT;
    localparam int QW     = MW + 1;
    localparam int CW     = $clog2(NSHIFT + 1);

    logic [PW-1:0] r_acc;
    logic [PW-1:0] r_mcand;
    logic [QW-1:0] r_q;       // sign-extended multiplier with implicit q[-1] at bit 0
    logic [CW-1:0] r_cnt;
    logic [PW-1:0] w_addend;

    // Booth digit from the overlapping triplet {q[2i+1], q[2i], q[2i-1]}
    always_comb begin
        w_addend = '0;
        case (r_q[2:0])
            3'b001, 3'b010: w_addend = r_mcand;
            3'b011:         w_addend = r_mcand << 1;
            3'b100:         w_addend = -(r_mcand << 1);
            3'b101, 3'b110: w_addend = -r_mcand;
            default:        w_addend = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_mcand <= '0;
            r_q     <= '0;
        end else if (i_start) begin
            r_acc   <= '0;
            r_mcand <= PW'($signed(i_multiplicand));
            r_q     <= {MW'($signed(i_multiplier)), 1'b0};
        end else if (i_en) begin
            r_acc   <= r_acc + w_addend;
            r_mcand <= r_mcand << 2;
            r_q     <= {{2{r_q[QW-1]}}, r_q[QW-1:2]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!i_rst_cntr_n) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_done   = (r_cnt == CW'(NSHIFT - 1));
    assign o_result = r_acc;

endmodule

// File: rtl/radix4_booth_multiplier.sv
// ---------------------------------------------------------------------------
// radix4_booth_multiplier
// Signed WIDTH x WIDTH multiplier: controller beside the iterative data path.
// Ports:
//   clk, rst_n                     - clock, asynchronous active-low reset
//   in_valid / in_ready            - operand handshake
//   in_multiplier, in_multiplicand - signed operands, WIDTH bits
//   out_valid / out_ready          - product handshake
//   out_result                     - signed product, 2*WIDTH bits
//   busy                           - operation in progress
// ---------------------------------------------------------------------------
module radix4_booth_multiplier #(
    parameter int WIDTH       = 8,
    parameter int CHECK_PARAM = 1
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_multiplier,
    input  logic [WIDTH-1:0]     in_multiplicand,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_result,
    output logic                 busy
);

    logic                 w_dp_start;
    logic                 w_dp_en;
    logic                 w_dp_rst_cntr_n;
    logic [WIDTH-1:0]     w_dp_multiplier;
    logic [WIDTH-1:0]     w_dp_multiplicand;
    logic                 w_dp_done;
    logic [2*WIDTH-1:0]   w_dp_result;

    radix4_booth_ctrl #(
        .WIDTH       (WIDTH),
        .CHECK_PARAM (CHECK_PARAM)
    ) u_ctrl (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_multiplier   (in_multiplier),
        .in_multiplicand (in_multiplicand),
        .dp_start        (w_dp_start),
        .dp_en           (w_dp_en),
        .dp_rst_cntr_n   (w_dp_rst_cntr_n),
        .dp_multiplier   (w_dp_multiplier),
        .dp_multiplicand (w_dp_multiplicand),
        .dp_done         (w_dp_done),
        .dp_result       (w_dp_result),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_result      (out_result),
        .busy            (busy)
    );

    radix4_booth_data_path #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_start        (w_dp_start),
        .i_en           (w_dp_en),
        .i_rst_cntr_n   (w_dp_rst_cntr_n),
        .i_multiplier   (w_dp_multiplier),
        .i_multiplicand (w_dp_multiplicand),
        .o_done         (w_dp_done),
        .o_result       (w_dp_result)
    );

endmodule

// File: rtl/radix4_booth_ctrl.sv
// ---------------------------------------------------------------------------
// radix4_booth_ctrl
// Handshaked sequencing controller for the iterative radix-4 Booth data path.
// One operation in flight; the product is held in an output register until
// the consumer takes it.
// Ports:
//   clk, rst_n                     - clock, asynchronous active-low reset
//   in_valid / in_ready            - operand handshake
//   in_multiplier, in_multiplicand - signed operands, WIDTH bits
//   dp_start                       - data-path load strobe (LOAD only)
//   dp_en                          - data-path iteration enable (RUN only)
//   dp_rst_cntr_n                  - registered data-path counter clear
//   dp_multiplier, dp_multiplicand - registered operands to the data path
//   dp_done, dp_result             - data-path last-iteration flag / product
//   out_valid / out_ready          - product handshake
//   out_result                     - signed product, 2*WIDTH bits
//   busy                           - high whenever not IDLE
// ---------------------------------------------------------------------------
module radix4_booth_ctrl
    import radix4_booth_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int CHECK_PARAM = 1
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_multiplier,
    input  logic [WIDTH-1:0]     in_multiplicand,
    output logic                 dp_start,
    output logic                 dp_en,
    output logic                 dp_rst_cntr_n,
    output logic [WIDTH-1:0]     dp_multiplier,
    output logic [WIDTH-1:0]     dp_multiplicand,
    input  logic                 dp_done,
    input  logic [2*WIDTH-1:0]   dp_result,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_result,
    output logic                 busy
);

    localparam int NSHIFT = num_shifts(WIDTH);
    localparam int CW     = $clog2(NSHIFT + 1);

    generate
        if (CHECK_PARAM != 0 && WIDTH < MIN_WIDTH) begin : g_width_check
            $fatal(1, "radix4_booth_ctrl: WIDTH=%0d below minimum %0d", WIDTH, MIN_WIDTH);
        end
    endgenerate

    booth_state_e           r_state;
    booth_state_e           w_state_next;
    logic [WIDTH-1:0]       r_dp_multiplier;
    logic [WIDTH-1:0]       r_dp_multiplicand;
    logic                   r_dp_rst_cntr_n;
    logic [CW-1:0]          r_run_cnt;
    logic                   r_out_valid;
    logic [2*WIDTH-1:0]     r_out_result;
    logic                   w_capt_ok;

    // Output register can take a new product if empty or being drained now
    assign w_capt_ok = !r_out_valid || out_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)  w_state_next = ST_LOAD;
            ST_LOAD:                w_state_next = ST_RUN;
            ST_RUN:  if (dp_done)   w_state_next = ST_CAPT;
            ST_CAPT: if (w_capt_ok) w_state_next = ST_IDLE;
            default:                w_state_next = ST_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b1;
        dp_start = 1'b0;
        dp_en    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            ST_LOAD: dp_start = 1'b1;
            ST_RUN:  dp_en    = 1'b1;
            default: ;
        endcase
    end

    // Operand capture and counter-clear flop; the clear stays low from reset
    // until the first LOAD has been seen, and is re-asserted for each new LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dp_multiplier   <= '0;
            r_dp_multiplicand <= '0;
            r_dp_rst_cntr_n   <= 1'b0;
        end else if (r_state == ST_IDLE && in_valid) begin
            r_dp_multiplier   <= in_multiplier;
            r_dp_multiplicand <= in_multiplicand;
            r_dp_rst_cntr_n   <= 1'b0;
        end else if (r_state == ST_LOAD) begin
            r_dp_rst_cntr_n   <= 1'b1;
        end
    end

    // RUN-cycle counter, used only to cross-check the data-path done timing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run_cnt <= '0;
        end else if (r_state == ST_LOAD) begin
            r_run_cnt <= '0;
        end else if (r_state == ST_RUN) begin
            r_run_cnt <= r_run_cnt + CW'(1);
        end
    end

    // Output register: a capture in the same cycle as a drain keeps valid high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
        end else if (r_state == ST_CAPT && w_capt_ok) begin
            r_out_valid  <= 1'b1;
            r_out_result <= dp_result;
        end else if (r_out_valid && out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    assign dp_multiplier   = r_dp_multiplier;
    assign dp_multiplicand = r_dp_multiplicand;
    assign dp_rst_cntr_n   = r_dp_rst_cntr_n;
    assign out_valid       = r_out_valid;
    assign out_result      = r_out_result;

    a_dp_done_timing: assert property (@(posedge clk) disable iff (!rst_n)
        (r_state == ST_RUN) |-> (dp_done == (r_run_cnt == CW'(NSHIFT - 1))));

endmodule

// File: tb/tb_radix4_booth_ctrl.sv
// ---------------------------------------------------------------------------
// tb_radix4_booth_ctrl
// Self-checking bench for radix4_booth_ctrl driving the real data path.
// ---------------------------------------------------------------------------
module tb_radix4_booth_ctrl;

    localparam int WIDTH = 8;
    localparam int PW    = 2 * WIDTH;
    localparam int NRAND = 3000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_multiplier;
    logic [WIDTH-1:0]  in_multiplicand;
    logic              dp_start;
    logic              dp_en;
    logic              dp_rst_cntr_n;
    logic [WIDTH-1:0]  dp_multiplier;
    logic [WIDTH-1:0]  dp_multiplicand;
    logic              dp_done;
    logic [PW-1:0]     dp_result;
    logic              out_valid;
    logic              out_ready;
    logic [PW-1:0]     out_result;
    logic              busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    radix4_booth_ctrl #(
        .WIDTH       (WIDTH),
        .CHECK_PARAM (1)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_multiplier   (in_multiplier),
        .in_multiplicand (in_multiplicand),
        .dp_start        (dp_start),
        .dp_en           (dp_en),
        .dp_rst_cntr_n   (dp_rst_cntr_n),
        .dp_multiplier   (dp_multiplier),
        .dp_multiplicand (dp_multiplicand),
        .dp_done         (dp_done),
        .dp_result       (dp_result),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_result      (out_result),
        .busy            (busy)
    );

    radix4_booth_data_path #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_start        (dp_start),
        .i_en           (dp_en),
        .i_rst_cntr_n   (dp_rst_cntr_n),
        .i_multiplier   (dp_multiplier),
        .i_multiplicand (dp_multiplicand),
        .o_done         (dp_done),
        .o_result       (dp_result)
    );

    // Reference: plain signed integer product truncated to 2*WIDTH bits
    function automatic logic [PW-1:0] ref_product(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int ia;
        int ib;
        ia = int'($signed(a));
        ib = int'($signed(b));
        return PW'(ia * ib);
    endfunction

    // Offers one operand pair and waits for out_valid; lat = edges after handshake
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          output logic [PW-1:0] res, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        in_multiplier   = a;
        in_multiplicand = b;
        in_valid        = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = -1;
        res = out_result;
    endtask

    task automatic drain_output();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_multiplier = 8'h5A;
        in_multiplicand = 8'hA5;
        #3 rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid, dp_start, dp_en, dp_rst_cntr_n, busy, in_ready} !== 6'b000001) begin
            bad++;
            $display("FAIL reset_async_ctrl got=%b want=000001", {out_valid, dp_start, dp_en, dp_rst_cntr_n, busy, in_ready});
        end
        #10;
        total++;
        if (out_result !== '0) begin
            bad++;
            $display("FAIL reset_out_result got=%h want=0000", out_result);
        end
        total++;
        if ({dp_multiplier, dp_multiplicand} !== 16'h0000) begin
            bad++;
            $display("FAIL reset_dp_operands got=%h want=0000", {dp_multiplier, dp_multiplicand});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++;
            if (dp_rst_cntr_n !== 1'b0 || in_ready !== 1'b1) begin
                bad++;
                $display("FAIL post_reset_idle cyc=%0d rst_cntr_n=%b in_ready=%b want 0,1", i, dp_rst_cntr_n, in_ready);
            end
        end
    endtask

    task automatic test_basic();
        int lat;
        logic [PW-1:0] exp;
        exp = ref_product(8'd7, 8'hFD);
        @(negedge clk);
        out_ready = 1'b1;
        in_multiplier = 8'd7;
        in_multiplicand = 8'hFD;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_multiplier = 8'($urandom);
        in_multiplicand = 8'($urandom);
        lat = 0;
        total++;
        if ({dp_start, dp_en, dp_rst_cntr_n, in_ready, busy} !== 5'b10001) begin
            bad++;
            $display("FAIL load_outputs got=%b want=10001", {dp_start, dp_en, dp_rst_cntr_n, in_ready, busy});
        end
        while (!out_valid && lat < 40) begin
            total++;
            if ({dp_multiplier, dp_multiplicand} !== {8'd7, 8'hFD}) begin
                bad++;
                $display("FAIL operand_hold lat=%0d got=%h want=07fd", lat, {dp_multiplier, dp_multiplicand});
            end
            if (lat >= 1 && lat <= 4) begin
                total++;
                if ({dp_start, dp_en, dp_rst_cntr_n, in_ready, dp_done} !== {4'b0110, lat == 4}) begin
                    bad++;
                    $display("FAIL run_outputs lat=%0d got=%b want=%b", lat, {dp_start, dp_en, dp_rst_cntr_n, in_ready, dp_done}, {4'b0110, lat == 4});
                end
            end
            if (lat == 5) begin
                total++;
                if ({dp_en, dp_start, in_ready} !== 3'b000) begin
                    bad++;
                    $display("FAIL capt_outputs got=%b want=000", {dp_en, dp_start, in_ready});
                end
            end
            @(posedge clk); #1;
            lat++;
        end
        total++;
        if (lat != 6) begin
            bad++;
            $display("FAIL basic_latency got=%0d want=6", lat);
        end
        total++;
        if (out_result !== 16'hFFEB || out_result !== exp) begin
            bad++;
            $display("FAIL basic_7x-3 got=%h want=ffeb", out_result);
        end
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_drain got=%b want=0", out_valid);
        end
    endtask

    task automatic test_corners();
        logic [WIDTH-1:0] ta [3];
        logic [WIDTH-1:0] tb [3];
        logic [PW-1:0]    te [3];
        logic [PW-1:0]    res;
        int               lat;
        ta = '{8'h80, 8'h7F, 8'h00};
        tb = '{8'h80, 8'h80, 8'hFF};
        te = '{16'h4000, 16'hC080, 16'h0000};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run_op(ta[i], tb[i], res, lat);
            total++;
            if (res !== te[i] || lat != 6) begin
                bad++;
                $display("FAIL corner_%0d got=%h lat=%0d want=%h lat=6", i, res, lat, te[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [PW-1:0] res;
        int            lat;
        drain_output();
        @(negedge clk);
        out_ready = 1'b0;
        run_op(8'd5, 8'd6, res, lat);
        total++;
        if (res !== 16'h001E || lat != 6) begin
            bad++;
            $display("FAIL b2b_first got=%h lat=%0d want=001e lat=6", res, lat);
        end
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_ready_second got=%b want=1", in_ready);
        end
        in_multiplier = 8'hFE;
        in_multiplicand = 8'd9;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            total++;
            if ({out_valid, out_result, in_ready, busy} !== {1'b1, 16'h001E, 2'b01}) begin
                bad++;
                $display("FAIL b2b_stall c=%0d got v=%b r=%h rdy=%b busy=%b want 1,001e,0,1", c, out_valid, out_result, in_ready, busy);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({out_valid, out_result} !== {1'b1, 16'hFFEE}) begin
            bad++;
            $display("FAIL b2b_second got v=%b r=%h want 1,ffee", out_valid, out_result);
        end
        @(posedge clk); #1;
        total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL b2b_final got=%b want=01", {out_valid, in_ready});
        end
    endtask

    task automatic test_reset_midrun();
        logic [PW-1:0] res;
        int            lat;
        int            pulses;
        @(negedge clk);
        out_ready = 1'b1;
        in_multiplier = 8'd100;
        in_multiplicand = 8'd50;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++;
        if (dp_en !== 1'b1) begin
            bad++;
            $display("FAIL midrun_in_run got=%b want=1", dp_en);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid, dp_start, dp_en, dp_rst_cntr_n, busy, in_ready} !== 6'b000001) begin
            bad++;
            $display("FAIL midrun_reset_ctrl got=%b want=000001", {out_valid, dp_start, dp_en, dp_rst_cntr_n, busy, in_ready});
        end
        total++;
        if ({out_result, dp_multiplier, dp_multiplicand} !== 32'h0) begin
            bad++;
            $display("FAIL midrun_reset_data got=%h want=0", {out_result, dp_multiplier, dp_multiplicand});
        end
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) pulses++;
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL midrun_no_valid got=%0d want=0", pulses);
        end
        run_op(8'd3, 8'd3, res, lat);
        total++;
        if (res !== 16'h0009 || lat != 6) begin
            bad++;
            $display("FAIL midrun_next got=%h lat=%0d want=0009 lat=6", res, lat);
        end
    endtask

    task automatic test_random();
        logic [PW-1:0]    q [$];
        logic [PW-1:0]    held;
        logic [PW-1:0]    want;
        logic [WIDTH-1:0] corner [4];
        logic             offering;
        logic             hold_pending;
        int               accepted;
        int               consumed;
        int               cyc;
        corner = '{8'h80, 8'h7F, 8'h00, 8'hFF};
        drain_output();
        accepted = 0;
        consumed = 0;
        cyc = 0;
        offering = 1'b0;
        hold_pending = 1'b0;
        held = '0;
        while ((accepted < NRAND || consumed < accepted) && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            if (hold_pending) begin
                total++;
                if ({out_valid, out_result} !== {1'b1, held}) begin
                    bad++;
                    $display("FAIL rand_hold cyc=%0d got v=%b r=%h want 1,%h", cyc, out_valid, out_result, held);
                end
            end
            if (!offering && accepted < NRAND && $urandom_range(0, 3) != 0) begin
                offering = 1'b1;
                in_multiplier   = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)] : 8'($urandom);
                in_multiplicand = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)] : 8'($urandom);
            end
            in_valid  = offering;
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (in_valid && in_ready) begin
                q.push_back(ref_product(in_multiplier, in_multiplicand));
                accepted++;
                offering = 1'b0;
            end
            if (out_valid && out_ready) begin
                want = (q.size() > 0) ? q.pop_front() : ~out_result;
                total++;
                if (out_result !== want) begin
                    bad++;
                    $display("FAIL rand_product n=%0d got=%h want=%h", consumed, out_result, want);
                end
                consumed++;
            end
            hold_pending = out_valid && !out_ready;
            held = out_result;
        end
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (consumed != NRAND || q.size() != 0) begin
            bad++;
            $display("FAIL rand_complete got=%0d pending=%0d want=%0d pending=0", consumed, q.size(), NRAND);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_back_to_back();
        test_reset_midrun();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
